// File: rtl/io_read_port_fifo.sv
// io_read_port_fifo
// Input buffer for one Octavo I/O read port. A producer pushes words over a
// valid/ready stream; the CPU sees the oldest word and a registered
// empty/full flag, and pops with io_rden. Head word and flag are registered
// so they hold steady between pops across the CPU thread pipeline.
module io_read_port_fifo #(
   parameter int unsigned WORD_WIDTH = 36,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned ADDR_WIDTH = 3,
   parameter string       RAMSTYLE   = "MLAB, no_rw_check"
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [WORD_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [WORD_WIDTH-1:0] io_read_data,
   output logic                  io_read_EF,
   input  logic                  io_rden,
   output logic [ADDR_WIDTH:0]   fill_count,
   output logic                  underflow
);

   localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE   = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH:0]   C_COUNT_ONE = (ADDR_WIDTH + 1)'(1);

   (* ramstyle = RAMSTYLE *)
   logic [WORD_WIDTH-1:0] r_mem [DEPTH];

   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  r_ef;
   logic                  r_underflow;
   logic [WORD_WIDTH-1:0] r_head;

   logic                  w_full;
   logic                  w_in_ready;
   logic                  w_push;
   logic                  w_pop;
   logic [ADDR_WIDTH-1:0] w_rd_ptr_next;
   logic [ADDR_WIDTH:0]   w_count_next;
   logic [WORD_WIDTH-1:0] w_head_next;

   // DEPTH is a power of two, so the count MSB alone marks "full".
   assign w_full        = r_count[ADDR_WIDTH];
   assign w_in_ready    = ~reset & ~w_full;
   assign w_push        = in_valid & w_in_ready;
   assign w_pop         = io_rden & r_ef & ~reset;
   assign w_rd_ptr_next = r_rd_ptr + C_PTR_ONE;

   // Next occupancy and next head word presented to the CPU.
   always_comb begin
      w_count_next = r_count;
      unique case ({w_push, w_pop})
         2'b10:   w_count_next = r_count + C_COUNT_ONE;
         2'b01:   w_count_next = r_count - C_COUNT_ONE;
         default: w_count_next = r_count;
      endcase

      // The head register mirrors r_mem[r_rd_ptr]; when the buffer is empty
      // (or about to become empty) the incoming word bypasses the array, and
      // with nothing to replace it the last word is simply held.
      w_head_next = r_head;
      if (w_pop) begin
         if (r_count > C_COUNT_ONE) begin
            w_head_next = r_mem[w_rd_ptr_next];
         end else if (w_push) begin
            w_head_next = in_data;
         end
      end else if (w_push && (r_count == '0)) begin
         w_head_next = in_data;
      end
   end

   // Storage array write; contents need no reset since pointers gate them.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= in_data;
      end
   end

   // Pointers, occupancy, head register and flags.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_ef        <= 1'b0;
         r_head      <= '0;
         r_underflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= w_rd_ptr_next;
         end
         r_count <= w_count_next;
         r_ef    <= (w_count_next != '0);
         r_head  <= w_head_next;
         if (io_rden && !r_ef) begin
            r_underflow <= 1'b1;
         end
      end
   end

   assign in_ready     = w_in_ready;
   assign io_read_data = r_head;
   assign io_read_EF   = r_ef;
   assign fill_count   = r_count;
   assign underflow    = r_underflow;

endmodule

// File: tb/tb_io_read_port_fifo.sv
// Testbench for io_read_port_fifo: directed stimulus with a scoreboard
// queue of expected words and a separate monitor that checks the head word.
module tb_io_read_port_fifo;

   localparam int unsigned WW = 36;
   localparam int unsigned DP = 8;
   localparam int unsigned AW = 3;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [WW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [WW-1:0] io_read_data;
   logic          io_read_EF;
   logic          io_rden = 1'b0;
   logic [AW:0]   fill_count;
   logic          underflow;

   int n_pass  = 0;
   int n_total = 0;

   // reference state
   logic [WW-1:0] exp_q[$];
   logic [WW-1:0] m_last = '0;
   int            m_cnt  = 0;
   logic          m_uf   = 1'b0;

   io_read_port_fifo #(
      .WORD_WIDTH (WW),
      .DEPTH      (DP),
      .ADDR_WIDTH (AW)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .io_read_data (io_read_data),
      .io_read_EF   (io_read_EF),
      .io_rden      (io_rden),
      .fill_count   (fill_count),
      .underflow    (underflow)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Apply inputs for one cycle (called at posedge+1), update the model,
   // then check the registered outputs after the edge.
   task automatic step(input logic v, input logic [WW-1:0] d, input logic rd);
      logic acc;
      logic pop;
      in_valid = v;
      in_data  = d;
      io_rden  = rd;
      #1;
      chk("in_ready", {63'd0, in_ready}, {63'd0, (m_cnt < int'(DP))});
      acc = v && (m_cnt < int'(DP));
      pop = rd && (m_cnt != 0);
      if (acc) exp_q.push_back(d);
      if (rd && m_cnt == 0) m_uf = 1'b1;
      m_cnt = m_cnt + (acc ? 1 : 0) - (pop ? 1 : 0);
      @(posedge clock);
      #1;
      chk("fill_count", 64'(fill_count), 64'(m_cnt));
      chk("io_read_EF", {63'd0, io_read_EF}, {63'd0, (m_cnt != 0)});
      chk("underflow", {63'd0, underflow}, {63'd0, m_uf});
   endtask

   task automatic apply_reset(input logic v, input logic [WW-1:0] d, input logic rd);
      reset    = 1'b1;
      in_valid = v;
      in_data  = d;
      io_rden  = rd;
      #1;
      chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
      exp_q.delete();
      m_cnt  = 0;
      m_uf   = 1'b0;
      m_last = '0;
      @(posedge clock);
      #1;
      reset    = 1'b0;
      in_valid = 1'b0;
      io_rden  = 1'b0;
      chk("rst_fill", 64'(fill_count), 64'd0);
      chk("rst_EF", {63'd0, io_read_EF}, 64'd0);
      chk("rst_data", 64'(io_read_data), 64'd0);
      chk("rst_underflow", {63'd0, underflow}, 64'd0);
      #1;
      chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
   endtask

   // Monitor: between edges, compare the presented head word with the
   // scoreboard and retire it when the CPU strobes a pop.
   initial begin
      logic [WW-1:0] w;
      forever begin
         @(negedge clock);
         if (!reset) begin
            if (io_read_EF) begin
               if (exp_q.size() == 0) begin
                  n_total++;
                  $display("FAIL head_unexpected: got 0x%0h expected no word at %0t", io_read_data, $time);
               end else begin
                  chk("head", 64'(io_read_data), 64'(exp_q[0]));
                  if (io_rden) begin
                     w = exp_q.pop_front();
                     m_last = w;
                  end
               end
            end else begin
               chk("held_data", 64'(io_read_data), 64'(m_last));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      @(posedge clock);
      #1;
      apply_reset(1'b0, '0, 1'b0);

      // three pushes, head appears one edge after the first
      step(1'b1, 36'h1, 1'b0);
      chk("t1_EF", {63'd0, io_read_EF}, 64'd1);
      chk("t1_data", 64'(io_read_data), 64'h1);
      step(1'b1, 36'h2, 1'b0);
      step(1'b1, 36'h3, 1'b0);
      chk("t1_fill3", 64'(fill_count), 64'd3);
      chk("t1_uf", {63'd0, underflow}, 64'd0);

      // three single-cycle pops
      step(1'b0, '0, 1'b1);
      chk("t2_data2", 64'(io_read_data), 64'h2);
      step(1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b1);
      chk("t2_data3", 64'(io_read_data), 64'h3);
      step(1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b1);
      chk("t2_EF0", {63'd0, io_read_EF}, 64'd0);
      chk("t2_hold3", 64'(io_read_data), 64'h3);
      chk("t2_fill0", 64'(fill_count), 64'd0);

      // fill to capacity, blocked ninth word, pop frees one slot
      for (int i = 0; i < 8; i++) step(1'b1, WW'(36'h10 + i), 1'b0);
      chk("t3_fill8", 64'(fill_count), 64'd8);
      chk("t3_full_ready", {63'd0, in_ready}, 64'd0);
      step(1'b1, 36'h18, 1'b0);
      step(1'b1, 36'h18, 1'b1);
      chk("t3_head11", 64'(io_read_data), 64'h11);
      chk("t3_fill7", 64'(fill_count), 64'd7);
      step(1'b1, 36'h18, 1'b0);
      chk("t3_fill8b", 64'(fill_count), 64'd8);
      for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
      chk("t3_last18", 64'(io_read_data), 64'h18);
      chk("t3_EF0", {63'd0, io_read_EF}, 64'd0);

      // push and pop together at fill_count=1
      step(1'b1, 36'hA, 1'b0);
      step(1'b1, 36'hB, 1'b1);
      chk("t4_EF", {63'd0, io_read_EF}, 64'd1);
      chk("t4_dataB", 64'(io_read_data), 64'hB);
      chk("t4_fill1", 64'(fill_count), 64'd1);

      // concurrent traffic across pointer wrap
      for (int i = 0; i < 20; i++) begin
         step(1'($urandom_range(0, 1)), {4'h0, 32'($urandom)}, 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 16 && m_cnt > 0; i++) step(1'b0, '0, 1'b1);
      chk("t4_drained", 64'(fill_count), 64'd0);

      // underflow on empty read, sticky
      step(1'b0, '0, 1'b1);
      chk("t5_uf", {63'd0, underflow}, 64'd1);
      chk("t5_fill0", 64'(fill_count), 64'd0);
      for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0);
      chk("t5_uf_sticky", {63'd0, underflow}, 64'd1);

      // reset mid-stream with push and pop active
      for (int i = 0; i < 5; i++) step(1'b1, WW'(36'h20 + i), 1'b0);
      chk("t6_fill5", 64'(fill_count), 64'd5);
      apply_reset(1'b1, 36'h99, 1'b1);
      step(1'b1, 36'h42, 1'b0);
      chk("t6_after_push", 64'(io_read_data), 64'h42);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
